// File: rtl/branch_sequencer_pkg.sv
// ============================================================================
// Module  : branch_sequencer_pkg
// Brief   : Shared encodings and helpers for the branch sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_sequencer_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } brOp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } brState_t;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Statistics counters stick at their ceiling instead of wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] value, input logic [15:0] limit);
    return (value >= limit) ? value : value + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_sequencer_compare.sv
// ============================================================================
// Module  : branch_compare
// Brief   : Combinational BEQ/BNE/JMP resolution on the latched operands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_compare
  import branch_sequencer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  brOp_t             op,
  output logic              eq,
  output logic              taken
);

  assign eq = (a == b);

  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_sequencer.sv
// ============================================================================
// Module  : branch_sequencer
// Brief   : One-at-a-time branch evaluation, PC redirect and post-branch flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int          DATA_W       = 16,
  parameter int          PC_W         = 16,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [15:0] COUNT_LIMIT  = COUNT_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_op,
  input  logic [DATA_W-1:0] br_a,
  input  logic [DATA_W-1:0] br_b,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_offset,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic              stall,
  output logic [15:0]       branch_count,
  output logic [15:0]       taken_count
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  brState_t          r_state;
  brState_t          w_nextState;
  brOp_t             r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_offset;
  logic [FC_W-1:0]   r_flushCnt;
  logic [PC_W-1:0]   r_redirectPc;
  logic [15:0]       r_branchCount;
  logic [15:0]       r_takenCount;
  logic              w_eq;
  logic              w_taken;
  logic [PC_W-1:0]   w_target;

  branch_compare #(
    .DATA_W (DATA_W)
  ) u_compare (
    .a     (r_a),
    .b     (r_b),
    .op    (r_op),
    .eq    (w_eq),
    .taken (w_taken)
  );

  // PC arithmetic wraps modulo 2^PC_W; JMP carries an absolute target.
  assign w_target = (r_op == BR_JMP) ? r_offset : (r_pc + PC_W'(1) + r_offset);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (br_valid && (br_op != BR_NONE)) w_nextState = EVAL;
      EVAL:     w_nextState = w_taken ? REDIRECT : IDLE;
      REDIRECT: w_nextState = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      FLUSH:    if (r_flushCnt <= FC_W'(1)) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= BR_NONE;
      r_a           <= '0;
      r_b           <= '0;
      r_pc          <= '0;
      r_offset      <= '0;
      r_flushCnt    <= '0;
      r_redirectPc  <= '0;
      r_branchCount <= '0;
      r_takenCount  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (br_valid && (br_op != BR_NONE)) begin
            r_op     <= brOp_t'(br_op);
            r_a      <= br_a;
            r_b      <= br_b;
            r_pc     <= br_pc;
            r_offset <= br_offset;
          end
        end
        EVAL: begin
          r_branchCount <= satInc(r_branchCount, COUNT_LIMIT);
          if (w_taken) r_redirectPc <= w_target;
        end
        REDIRECT: begin
          r_takenCount <= satInc(r_takenCount, COUNT_LIMIT);
          r_flushCnt   <= FC_W'(FLUSH_CYCLES);
        end
        FLUSH: begin
          r_flushCnt <= r_flushCnt - FC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign br_ready       = (r_state == IDLE);
  assign stall          = (r_state != IDLE);
  assign redirect_valid = (r_state == REDIRECT);
  assign flush          = (r_state == REDIRECT) || (r_state == FLUSH);
  assign redirect_pc    = r_redirectPc;
  assign branch_count   = r_branchCount;
  assign taken_count    = r_takenCount;

endmodule

`default_nettype wire

// File: tb/tb_branch_sequencer.sv
// ============================================================================
// Module  : tb_branch_sequencer
// Brief   : Two sequencers (flush 2 / flush 0 with a low counter ceiling) on shared stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_op = 2'b00;
  logic [15:0] br_a = '0, br_b = '0, br_pc = '0, br_offset = '0;

  logic [1:0]       rdy, rv, fl, st;
  logic [1:0][15:0] rpc, bc, tc;

  int cyc = 0;
  int nCmp = 0;
  int nFail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_sequencer #(.DATA_W(16), .PC_W(16), .FLUSH_CYCLES(2), .COUNT_LIMIT(16'hFFFF)) dut0 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy[0]), .br_op(br_op),
    .br_a(br_a), .br_b(br_b), .br_pc(br_pc), .br_offset(br_offset),
    .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .flush(fl[0]), .stall(st[0]),
    .branch_count(bc[0]), .taken_count(tc[0]));

  branch_sequencer #(.DATA_W(16), .PC_W(16), .FLUSH_CYCLES(0), .COUNT_LIMIT(16'd20)) dut1 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy[1]), .br_op(br_op),
    .br_a(br_a), .br_b(br_b), .br_pc(br_pc), .br_offset(br_offset),
    .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .flush(fl[1]), .stall(st[1]),
    .branch_count(bc[1]), .taken_count(tc[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted branch defines a timeline relative to its accept cycle.
  int          mFlush [2] = '{2, 0};
  int          mLimit [2] = '{65535, 20};
  int          mAcc   [2];
  bit          mTaken [2];
  logic [15:0] mTarget[2];
  logic [15:0] mRpc   [2];
  int          mBc    [2];
  int          mTc    [2];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mAcc[i] = -100; mTaken[i] = 1'b0; mTarget[i] = '0;
      mRpc[i] = '0;   mBc[i] = 0;       mTc[i] = 0;
    end
  endtask

  initial modelReset();

  always @(negedge clk) begin
    if (!rst_n) begin
      modelReset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int  d;
        bit  eRdy, eRv, eFl;
        d = cyc - mAcc[i];
        if (d == 2 && mBc[i] < mLimit[i]) mBc[i]++;
        if (d == 2 && mTaken[i]) mRpc[i] = mTarget[i];
        if (d == 3 && mTaken[i] && mTc[i] < mLimit[i]) mTc[i]++;
        eRv  = mTaken[i] && d == 2;
        eFl  = mTaken[i] && d >= 2 && d <= 2 + mFlush[i];
        eRdy = !(d >= 1 && d < (mTaken[i] ? 3 + mFlush[i] : 2));
        chk($sformatf("d%0d.br_ready", i), 32'(rdy[i]), 32'(eRdy));
        chk($sformatf("d%0d.stall", i), 32'(st[i]), 32'(!eRdy));
        chk($sformatf("d%0d.redirect_valid", i), 32'(rv[i]), 32'(eRv));
        chk($sformatf("d%0d.flush", i), 32'(fl[i]), 32'(eFl));
        chk($sformatf("d%0d.redirect_pc", i), 32'(rpc[i]), 32'(mRpc[i]));
        chk($sformatf("d%0d.branch_count", i), 32'(bc[i]), 32'(mBc[i]));
        chk($sformatf("d%0d.taken_count", i), 32'(tc[i]), 32'(mTc[i]));
        if (br_valid && eRdy && br_op != 2'b00) begin
          mAcc[i] = cyc;
          case (br_op)
            2'b01:   mTaken[i] = (br_a == br_b);
            2'b10:   mTaken[i] = (br_a != br_b);
            default: mTaken[i] = 1'b1;
          endcase
          mTarget[i] = (br_op == 2'b11) ? br_offset : 16'(br_pc + 16'd1 + br_offset);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (rdy != 2'b11) begin
      step(1);
      n++;
      if (n > 50) begin
        chk("wait_idle_timeout", 32'(rdy), 32'h3);
        return;
      end
    end
  endtask

  // Returns one cycle after acceptance (both sequencers in EVAL).
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input logic [15:0] off);
    waitIdle();
    br_valid = 1'b1; br_op = op; br_a = a; br_b = b; br_pc = pc; br_offset = off;
    step(1);
    br_valid = 1'b0; br_op = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset.br_ready", 32'(rdy), 32'h3);
    chk("reset.flush", 32'(fl), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // BNE taken: 0x10 + 1 + 4 = 0x15, flush cycles 2..4 on dut0
    issue(2'b10, 16'h0005, 16'h0007, 16'h0010, 16'h0004);
    step(1);
    chk("bne.redirect_valid", 32'(rv[0]), 32'h1);
    chk("bne.redirect_pc", 32'(rpc[0]), 32'h0015);
    step(2);
    chk("bne.flush_c4", 32'(fl[0]), 32'h1);
    step(1);
    chk("bne.flush_c5", 32'(fl[0]), 32'h0);
    chk("bne.ready_c5", 32'(rdy[0]), 32'h1);
    chk("bne.taken_count", 32'(tc[0]), 32'h1);
    chk("bne.branch_count", 32'(bc[0]), 32'h1);

    // BEQ not taken: one stall cycle, ready again in cycle 2
    issue(2'b01, 16'h1234, 16'h1235, 16'h0040, 16'h0008);
    chk("beqnt.stall_c1", 32'(st[0]), 32'h1);
    step(1);
    chk("beqnt.ready_c2", 32'(rdy[0]), 32'h1);
    chk("beqnt.flush", 32'(fl[0]), 32'h0);
    chk("beqnt.branch_count", 32'(bc[0]), 32'h2);
    chk("beqnt.redirect_pc_held", 32'(rpc[0]), 32'h0015);

    // Negative offset and wrap-around
    issue(2'b01, 16'hFFFF, 16'hFFFF, 16'h0002, 16'hFFF0);
    step(1);
    chk("neg.redirect_pc", 32'(rpc[0]), 32'hFFF3);
    issue(2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001);
    step(1);
    chk("wrap.redirect_pc", 32'(rpc[0]), 32'h0001);

    // JMP: dut1 has no flush tail
    issue(2'b11, 16'h0000, 16'h0000, 16'h1000, 16'h0200);
    step(1);
    chk("jmp.redirect_pc", 32'(rpc[1]), 32'h0200);
    chk("jmp.flush_c2", 32'(fl[1]), 32'h1);
    step(1);
    chk("jmp.flush_c3", 32'(fl[1]), 32'h0);
    chk("jmp.ready_c3", 32'(rdy[1]), 32'h1);
    chk("jmp.dut0_flush_c3", 32'(fl[0]), 32'h1);

    // Async reset while dut0 sits in FLUSH
    issue(2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h0300);
    step(2);
    chk("rst.pre_flush", 32'(fl[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.ready", 32'(rdy[0]), 32'h1);
    chk("rst.flush", 32'(fl[0]), 32'h0);
    chk("rst.stall", 32'(st[0]), 32'h0);
    chk("rst.branch_count", 32'(bc[0]), 32'h0);
    chk("rst.taken_count", 32'(tc[0]), 32'h0);
    chk("rst.redirect_pc", 32'(rpc[0]), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // br_op = 00 handshakes are consumed without effect
    br_valid = 1'b1; br_op = 2'b00;
    step(2);
    br_valid = 1'b0;
    chk("none.ready", 32'(rdy), 32'h3);
    chk("none.branch_count", 32'(bc[0]), 32'h0);
    step(1);

    // Saturation: dut1 ceiling is 20
    for (int k = 0; k < 22; k++) issue(2'b10, 16'h00AA, 16'h00AA, 16'h0100, 16'h0001);
    waitIdle();
    step(1);
    chk("sat.dut1_branch_count", 32'(bc[1]), 32'd20);
    chk("sat.dut1_taken_count", 32'(tc[1]), 32'd0);
    chk("sat.dut0_branch_count", 32'(bc[0]), 32'd22);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

`default_nettype wire
